// File: rtl/snes_to_coleco_ctrl_pkg.sv
// Shared definitions for the SNES-to-ColecoVision adapter: button bit positions,
// keypad nibble codes and the pad reader state encoding.
package snes_to_coleco_ctrl_pkg;

    localparam int BTN_B     = 0;
    localparam int BTN_Y     = 1;
    localparam int BTN_SEL   = 2;
    localparam int BTN_START = 3;
    localparam int BTN_UP    = 4;
    localparam int BTN_DOWN  = 5;
    localparam int BTN_LEFT  = 6;
    localparam int BTN_RIGHT = 7;
    localparam int BTN_A     = 8;
    localparam int BTN_X     = 9;
    localparam int BTN_L     = 10;
    localparam int BTN_R     = 11;

    // Nibbles as seen on {p4,p3,p2,p1} for the ColecoVision keypad matrix
    localparam logic [3:0] KEY_1    = 4'hD;
    localparam logic [3:0] KEY_2    = 4'h7;
    localparam logic [3:0] KEY_3    = 4'hC;
    localparam logic [3:0] KEY_4    = 4'h2;
    localparam logic [3:0] KEY_STAR = 4'h6;
    localparam logic [3:0] KEY_HASH = 4'h9;
    localparam logic [3:0] KEY_NONE = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } pad_state_t;

    // Only one key can be reported at a time; earlier entries win.
    function automatic logic [3:0] key_nibble(input logic [11:0] b);
        logic [3:0] nib;
        nib = KEY_NONE;
        if (b[BTN_START])
            nib = KEY_HASH;
        else if (b[BTN_SEL])
            nib = KEY_STAR;
        else if (b[BTN_Y])
            nib = KEY_1;
        else if (b[BTN_X])
            nib = KEY_2;
        else if (b[BTN_L])
            nib = KEY_3;
        else if (b[BTN_R])
            nib = KEY_4;
        return nib;
    endfunction

endpackage

// File: rtl/snes_pad_reader.sv
// Periodically polls an SNES pad over latch/clock/data and commits the
// 12 button bits when the 4 trailing signature bits read as released.
module snes_pad_reader
    import snes_to_coleco_ctrl_pkg::*;
#(
    parameter int CLK_DIV  = 21,
    parameter int POLL_DIV = 59659
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        snes_data,
    output logic        snes_latch,
    output logic        snes_clk,
    output logic [11:0] buttons
);

    localparam int TW = $clog2(2 * CLK_DIV);
    localparam int PW = $clog2(POLL_DIV);
    localparam logic [TW-1:0] T_LOW_END  = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] T_SLOT_END = TW'(2 * CLK_DIV - 1);
    localparam logic [PW-1:0] POLL_END   = PW'(POLL_DIV - 1);

    pad_state_t     state;
    pad_state_t     next_state;
    logic [1:0]     data_sync;
    logic           sync_data;
    logic [PW-1:0]  poll_cnt;
    logic           poll_tick;
    logic [TW-1:0]  tmr;
    logic [3:0]     bit_idx;
    logic [15:0]    shadow;

    // Pad data is asynchronous to clk; it idles high, so the chain does too.
    always_ff @(posedge clk) begin
        if (rst)
            data_sync <= 2'b11;
        else
            data_sync <= {data_sync[0], snes_data};
    end

    assign sync_data = data_sync[1];

    always_ff @(posedge clk) begin
        if (rst)
            poll_cnt <= '0;
        else if (poll_cnt == POLL_END)
            poll_cnt <= '0;
        else
            poll_cnt <= poll_cnt + 1'b1;
    end

    assign poll_tick = (poll_cnt == POLL_END);

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        snes_latch = 1'b0;
        snes_clk   = 1'b1;
        case (state)
            ST_IDLE: begin
                if (poll_tick)
                    next_state = ST_LATCH;
            end
            ST_LATCH: begin
                snes_latch = 1'b1;
                if (tmr == T_SLOT_END)
                    next_state = ST_READ;
            end
            ST_READ: begin
                snes_clk = (tmr > T_LOW_END);
                if (tmr == T_SLOT_END && bit_idx == 4'd15)
                    next_state = ST_DONE;
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // The pad drives low for pressed, so the inverted sample lands in shadow.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmr     <= '0;
            bit_idx <= '0;
            shadow  <= '0;
            buttons <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    tmr <= '0;
                end
                ST_LATCH: begin
                    bit_idx <= '0;
                    shadow  <= '0;
                    tmr     <= (tmr == T_SLOT_END) ? '0 : tmr + 1'b1;
                end
                ST_READ: begin
                    if (tmr == T_LOW_END)
                        shadow[bit_idx] <= ~sync_data;
                    if (tmr == T_SLOT_END) begin
                        tmr     <= '0;
                        bit_idx <= bit_idx + 1'b1;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (shadow[15:12] == 4'h0)
                        buttons <= shadow[11:0];
                end
                default: begin
                    tmr <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/snes_to_coleco_ctrl.sv
// One SNES pad presented as a ColecoVision controller port; the glue block's
// select strobes choose between joystick and keypad views of the buttons.
module snes_to_coleco_ctrl
    import snes_to_coleco_ctrl_pkg::*;
#(
    parameter int CLK_DIV  = 21,
    parameter int POLL_DIV = 59659
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cp5_arm,
    input  logic        cp8_fire,
    input  logic        snes_data,
    output logic        snes_latch,
    output logic        snes_clk,
    output logic        p1,
    output logic        p2,
    output logic        p3,
    output logic        p4,
    output logic        p6,
    output logic        p7,
    output logic        p9,
    output logic [11:0] buttons
);

    logic [3:0] nib_next;
    logic       fire_next;

    snes_pad_reader #(
        .CLK_DIV  (CLK_DIV),
        .POLL_DIV (POLL_DIV)
    ) u_reader (
        .clk        (clk),
        .rst        (rst),
        .snes_data  (snes_data),
        .snes_latch (snes_latch),
        .snes_clk   (snes_clk),
        .buttons    (buttons)
    );

    // Joystick select wins when the glue drives both strobes low.
    always_comb begin
        nib_next  = 4'hF;
        fire_next = 1'b1;
        if (!cp8_fire) begin
            nib_next  = {~buttons[BTN_RIGHT], ~buttons[BTN_LEFT],
                         ~buttons[BTN_DOWN],  ~buttons[BTN_UP]};
            fire_next = ~buttons[BTN_B];
        end else if (!cp5_arm) begin
            nib_next  = key_nibble(buttons);
            fire_next = ~buttons[BTN_A];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            {p4, p3, p2, p1} <= 4'hF;
            p6               <= 1'b1;
        end else begin
            {p4, p3, p2, p1} <= nib_next;
            p6               <= fire_next;
        end
    end

    // No spinner is emulated.
    assign p7 = 1'b1;
    assign p9 = 1'b1;

endmodule
